sw_debounce_bank: RTL and testbench

//   Parametrised N-channel switch conditioner for board top levels.
//   - Per channel: synchronises a raw slide switch / button into clk, debounces it

---
 rtl/sw_debounce_pkg.sv | 16 +
 rtl/sw_debounce_ch.sv | 97 +++++++++
 rtl/sw_debounce_bank.sv | 54 +++++
 tb/tb_sw_debounce_bank.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// rtl/sw_debounce_pkg.sv - shared constants, FSM encodings and width helper for the switch debouncer
package sw_debounce_pkg;

  localparam int DEF_TICK_DIV     = 1000;
  localparam int DEF_STABLE_TICKS = 10000;
  localparam int DEF_SYNC_STAGES  = 2;

  localparam logic ST_STABLE  = 1'b0;
  localparam logic ST_PENDING = 1'b1;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// rtl/sw_debounce_ch.sv - one switch channel: synchroniser, debounce FSM, edge pulses, optional toggle (SW_DEBOUNCE_TOGGLE_EN)
module debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic sw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic toggle_o
);

  localparam int             CW   = clog2_min1(STABLE_TICKS + 1);
  localparam logic [CW-1:0]  CMAX = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sw_sync;
  logic                   state;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sw_sync = sync_q[SYNC_STAGES-1];

  // The channel is pending whenever the synchronised input disagrees with the committed level;
  // this lets a change count a tick in the very cycle it becomes visible.
  assign state = (sw_sync != level_q) ? ST_PENDING : ST_STABLE;

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
  end

  // Debounce decision: count ticks while pending, commit after STABLE_TICKS of them.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state)
      ST_STABLE: cnt_d = '0;
      default: begin
        if (tick_i) begin
          if (cnt_q == CMAX) begin
            cnt_d   = '0;
            level_d = sw_sync;
            rise_d  = sw_sync;
            fall_d  = ~sw_sync;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    endcase
  end

  // Register level, counter and edge pulses so the pulses line up with the level edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef SW_DEBOUNCE_TOGGLE_EN
  logic toggle_q;

  // Flip the toggle state on every rising-edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) toggle_q <= 1'b0;
    else     toggle_q <= toggle_q ^ rise_q;
  end

  assign toggle_o = toggle_q;
`else
  assign toggle_o = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce_bank.sv
// rtl/sw_debounce_bank.sv - N-channel switch debouncer with shared tick prescaler (toggle outputs under SW_DEBOUNCE_TOGGLE_EN)
module sw_debounce_bank
  import sw_debounce_pkg::*;
#(
  parameter int N_CH         = 16,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] sw_level,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall,
  output logic [N_CH-1:0] sw_toggle,
  output logic            tick
);

  localparam int            PW   = clog2_min1(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;

  // Prescaler wraps after TICK_DIV cycles; tick marks the last cycle of each period.
  always_comb begin
    pcnt_d = (pcnt_q == PMAX) ? '0 : pcnt_q + PW'(1);
  end

  // Prescaler count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

  assign tick = (pcnt_q == PMAX);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick_i  (tick),
      .sw_i    (sw_in[i]),
      .level_o (sw_level[i]),
      .rise_o  (sw_rise[i]),
      .fall_o  (sw_fall[i]),
      .toggle_o(sw_toggle[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce_bank.sv
// tb/tb_sw_debounce_bank.sv - directed self-checking bench for sw_debounce_bank
module tb_sw_debounce_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw_in = 4'h0;
  logic [3:0] sw_level, sw_rise, sw_fall, sw_toggle;
  logic       tick;

  int vec  = 0;
  int errs = 0;

  int rise_cnt[4] = '{default: 0};
  int fall_cnt[4] = '{default: 0};
  int lvl_chg[4]  = '{default: 0};
  int both_hi     = 0;
  int tog_seen    = 0;
  logic [3:0] prev_lvl = 4'h0;

  sw_debounce_bank #(
    .N_CH(4), .SYNC_STAGES(2), .TICK_DIV(4), .STABLE_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .sw_level(sw_level),
    .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_toggle(sw_toggle), .tick(tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (sw_rise[i] === 1'b1) rise_cnt[i]++;
      if (sw_fall[i] === 1'b1) fall_cnt[i]++;
      if (sw_rise[i] === 1'b1 && sw_fall[i] === 1'b1) both_hi++;
      if (sw_level[i] !== prev_lvl[i]) lvl_chg[i]++;
    end
    prev_lvl = sw_level;
`ifndef SW_DEBOUNCE_TOGGLE_EN
    if (sw_toggle !== 4'h0) tog_seen++;
`endif
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw_in = 4'h0;
    cyc(3);
    vec++; if (sw_level !== 4'h0) begin errs++; $display("FAIL reset_level: got %h want 0", sw_level); end
    vec++; if (sw_rise !== 4'h0) begin errs++; $display("FAIL reset_rise: got %h want 0", sw_rise); end
    vec++; if (sw_fall !== 4'h0) begin errs++; $display("FAIL reset_fall: got %h want 0", sw_fall); end
    vec++; if (sw_toggle !== 4'h0) begin errs++; $display("FAIL reset_toggle: got %h want 0", sw_toggle); end
    vec++; if (tick !== 1'b0) begin errs++; $display("FAIL reset_tick: got %b want 0", tick); end
    rst = 1'b0;
  endtask

  task automatic test_prescaler();
    logic exp;
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      exp = ((k % 4) == 3);
      vec++; if (tick !== exp) begin errs++; $display("FAIL tick_k%0d: got %b want %b", k, tick, exp); end
    end
  endtask

  task automatic test_clean_press();
    int br = rise_cnt[0];
    int bf = fall_cnt[0];
    int hit = 0;
    sw_in[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (hit == 0 && sw_level[0] === 1'b1) begin
        hit = k;
        vec++; if (sw_rise[0] !== 1'b1) begin errs++; $display("FAIL press_rise_align: got %b want 1", sw_rise[0]); end
      end
    end
    vec++; if (hit < 11 || hit > 14) begin errs++; $display("FAIL press_latency: got %0d want 11..14", hit); end
    vec++; if (rise_cnt[0] - br !== 1) begin errs++; $display("FAIL press_rise_cycles: got %0d want 1", rise_cnt[0] - br); end
    vec++; if (fall_cnt[0] - bf !== 0) begin errs++; $display("FAIL press_fall: got %0d want 0", fall_cnt[0] - bf); end
    vec++; if (sw_level !== 4'b0001) begin errs++; $display("FAIL press_level: got %b want 0001", sw_level); end
  endtask

  task automatic test_bounce();
    int br = rise_cnt[1];
    int bf = fall_cnt[1];
    int bl = lvl_chg[1];
    for (int t = 0; t < 10; t++) begin
      sw_in[1] = ~sw_in[1];
      cyc(3);
    end
    sw_in[1] = 1'b1;
    cyc(20);
    vec++; if (sw_level[1] !== 1'b1) begin errs++; $display("FAIL bounce_level: got %b want 1", sw_level[1]); end
    vec++; if (rise_cnt[1] - br !== 1) begin errs++; $display("FAIL bounce_rise: got %0d want 1", rise_cnt[1] - br); end
    vec++; if (fall_cnt[1] - bf !== 0) begin errs++; $display("FAIL bounce_fall: got %0d want 0", fall_cnt[1] - bf); end
    vec++; if (lvl_chg[1] - bl !== 1) begin errs++; $display("FAIL bounce_transitions: got %0d want 1", lvl_chg[1] - bl); end
  endtask

  task automatic test_glitch();
    int br = rise_cnt[2];
    int bf = fall_cnt[2];
    sw_in[2] = 1'b1;
    cyc(6);
    sw_in[2] = 1'b0;
    cyc(20);
    vec++; if (sw_level[2] !== 1'b0) begin errs++; $display("FAIL glitch_level: got %b want 0", sw_level[2]); end
    vec++; if (rise_cnt[2] - br !== 0) begin errs++; $display("FAIL glitch_rise: got %0d want 0", rise_cnt[2] - br); end
    vec++; if (fall_cnt[2] - bf !== 0) begin errs++; $display("FAIL glitch_fall: got %0d want 0", fall_cnt[2] - bf); end
  endtask

  task automatic test_simultaneous();
    int hit = 0;
    sw_in[1] = 1'b0;
    sw_in[3] = 1'b1;
    cyc(20);
    vec++; if (sw_level !== 4'b1001) begin errs++; $display("FAIL simul_setup_level: got %b want 1001", sw_level); end
    sw_in[1] = 1'b1;
    sw_in[3] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (hit == 0 && (sw_rise[1] === 1'b1 || sw_fall[3] === 1'b1)) begin
        hit = k;
        vec++; if ({sw_rise[1], sw_fall[3]} !== 2'b11) begin errs++; $display("FAIL simul_same_cycle: got rise1=%b fall3=%b want 1 1", sw_rise[1], sw_fall[3]); end
      end
    end
    vec++; if (hit == 0) begin errs++; $display("FAIL simul_seen: got no pulse want pulse within 20 cycles"); end
    vec++; if (sw_level !== 4'b0011) begin errs++; $display("FAIL simul_level: got %b want 0011", sw_level); end
  endtask

  task automatic test_reset_mid();
    int br[4];
    int hit = 0;
    sw_in = 4'hF;
    cyc(20);
    vec++; if (sw_level !== 4'hF) begin errs++; $display("FAIL rstmid_pre_level: got %h want f", sw_level); end
    rst = 1'b1;
    #1;
    vec++; if (sw_level !== 4'h0) begin errs++; $display("FAIL rstmid_async_level: got %h want 0", sw_level); end
    vec++; if ({sw_rise, sw_fall} !== 8'h00) begin errs++; $display("FAIL rstmid_async_pulses: got %h want 00", {sw_rise, sw_fall}); end
    cyc(2);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) br[i] = rise_cnt[i];
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (hit == 0 && sw_level === 4'hF) hit = k;
    end
    vec++; if (hit < 11 || hit > 14) begin errs++; $display("FAIL rstmid_latency: got %0d want 11..14", hit); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (rise_cnt[i] - br[i] !== 1) begin errs++; $display("FAIL rstmid_rise_ch%0d: got %0d want 1", i, rise_cnt[i] - br[i]); end
    end
  endtask

  task automatic test_toggle();
    logic exp;
    rst = 1'b1;
    sw_in = 4'h0;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    for (int p = 0; p < 3; p++) begin
      sw_in[0] = 1'b1;
      cyc(20);
`ifdef SW_DEBOUNCE_TOGGLE_EN
      exp = ((p % 2) == 0);
`else
      exp = 1'b0;
`endif
      vec++; if (sw_toggle[0] !== exp) begin errs++; $display("FAIL toggle_press%0d: got %b want %b", p, sw_toggle[0], exp); end
      sw_in[0] = 1'b0;
      cyc(20);
    end
    vec++; if (sw_toggle[3:1] !== 3'b000) begin errs++; $display("FAIL toggle_others: got %b want 000", sw_toggle[3:1]); end
    vec++; if (tog_seen !== 0) begin errs++; $display("FAIL toggle_never_set: got %0d cycles want 0", tog_seen); end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_toggle();
    vec++; if (both_hi !== 0) begin errs++; $display("FAIL rise_fall_exclusive: got %0d cycles want 0", both_hi); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
